uart_rx_cmd_ctrl: RTL and testbench
===================================

Name: uart_rx_cmd_ctrl

Overview:
Controller that sits beside the UART receiver and owns its run-time configuration (Prescale, PAR_EN, PAR_TYP). It parses the received byte stream into fixed command frames (SYNC, ADDR, DATA[, CHK]) and issues single-cycle register writes. It aborts frames on receiver errors or inter-byte timeout, and applies configuration changes only between frames while the line is idle.

Parameters:
DATA_WIDTH, 8, width of received bytes, address and data fields
SYNC_BYTE, 8'hA5, frame start marker
CFG_ADDR, 8'hFF, frame address that targets this block's own config instead of reg_*
TIMEOUT_BITS, 24, inter-byte timeout in bit periods; limit = cur_prescale * TIMEOUT_BITS clocks

Ports:
CLK  in  1  system clock, same clock as the UART receiver
RST  in  1  synchronous, active-high reset
rx_line  in  1  raw serial line, same signal as receiver RX_IN; 1 = idle
rx_data  in  DATA_WIDTH  receiver P_DATA
rx_valid  in  1  receiver data_valid; may stay high for several cycles, so each rising edge is one byte
rx_par_err  in  1  receiver par_err, sampled on the rx_valid rising edge
rx_stp_err  in  1  receiver stp_err, sampled on the rx_valid rising edge
cfg_wr  in  1  host config write strobe
cfg_prescale  in  6  host prescale request; legal values are 8, 16 and 32
cfg_par_en  in  1  host parity enable
cfg_par_typ  in  1  host parity type (0 even, 1 odd)
Prescale  out  6  to receiver
PAR_EN  out  1  to receiver
PAR_TYP  out  1  to receiver
cfg_pending  out  1  a config change is waiting to be applied
cfg_err  out  1  1-cycle pulse: illegal prescale requested
reg_wr_en  out  1  1-cycle register write strobe
reg_addr  out  DATA_WIDTH  write address, valid while reg_wr_en is high
reg_wr_data  out  DATA_WIDTH  write data, valid while reg_wr_en is high
frame_done  out  1  1-cycle pulse on every completed frame
frame_err  out  1  1-cycle pulse on every aborted frame
err_cnt  out  8  saturating count of errored bytes, timeouts and checksum failures

Behaviour:
- Reset values:
  - Prescale = 32, PAR_EN = 1, PAR_TYP = 0.
  - All strobes, cfg_pending, reg_addr, reg_wr_data and err_cnt = 0.
  - FSM = IDLE.
  - RST mid-frame discards the partial frame and any pending config.
- Byte event ("byte"): rx_valid is 1 now and was 0 in the previous cycle. Detection takes one registered cycle. Errored byte = byte with rx_par_err or rx_stp_err set.
- FSM states: IDLE, ADDR, DATA, CHK (only with the macro), EXEC.
  - IDLE:
    - clean byte equal to SYNC_BYTE -> ADDR;
    - any other clean byte is ignored;
    - errored byte -> err_cnt+1 and stay in IDLE.
  - ADDR: clean byte -> latch address, go to DATA.
  - DATA: clean byte -> latch data, go to CHK (macro defined) or EXEC.
  - EXEC, one cycle:
    - address != CFG_ADDR: reg_wr_en = 1 with the latched reg_addr/reg_wr_data.
    - address == CFG_ADDR: no reg_wr_en; data decoded as a config request. Bits[1:0]: 0 -> 8, 1 -> 16, 2 -> 32, 3 -> illegal (cfg_err pulse, request discarded). Bit2 = par_en, bit3 = par_typ.
    - In both cases frame_done = 1, then -> IDLE.
  - In ADDR/DATA/CHK: errored byte -> IDLE, frame_err pulse, err_cnt+1.
- Timeout:
  - A counter clears on every byte and on entry to ADDR, and counts every cycle while in ADDR, DATA or CHK.
  - On reaching cur_prescale*TIMEOUT_BITS: -> IDLE, frame_err pulse, err_cnt+1.
  - The counter must be at least 11 bits wide (32*24 = 768 max; size for a 6-bit prescale times TIMEOUT_BITS).
- Config handling:
  - Host cfg_wr:
    - cfg_prescale not in {8, 16, 32} -> cfg_err pulse, request ignored;
    - otherwise the request is stored in a pending register and cfg_pending = 1.
  - A newer request overwrites the pending one.
  - Host cfg_wr in the same cycle as an EXEC CFG_ADDR request: the host request wins.
  - Apply rule: in a cycle where the FSM is IDLE, cfg_pending = 1 and rx_line = 1, the pending values are copied to Prescale/PAR_EN/PAR_TYP on the next clock edge and cfg_pending clears.
  - Outputs never change while the FSM is outside IDLE or while rx_line = 0.
- err_cnt saturates at 255.
- A byte arriving in the EXEC cycle is still processed (as if the FSM were in IDLE) and is not lost.

Optional Feature:
FRAME_CHK_EN
- Defined: frames are 4 bytes. The CHK byte must equal SYNC_BYTE ^ addr ^ data.
  - Match -> EXEC.
  - Mismatch -> IDLE, frame_err pulse, err_cnt+1, no write.
- Undefined: frames are 3 bytes and the CHK state does not exist.

Test Plan:
- Frame A5,12,34 (plus CHK 83 if FRAME_CHK_EN) with Prescale 32 -> exactly one reg_wr_en pulse, reg_addr = 0x12, reg_wr_data = 0x34, one frame_done; err_cnt stays 0.
- Bytes 00,A5,12 followed by silence -> 00 ignored; after 768 clocks from the byte 12 edge: frame_err pulse, err_cnt = 1, no reg_wr_en.
- Frame A5,FF,0D (plus CHK 57 if FRAME_CHK_EN), then idle line -> Prescale = 16, PAR_EN = 1, PAR_TYP = 1, no reg_wr_en; cfg_pending low after apply.
- Host cfg_wr with prescale 8 issued mid-frame (FSM in DATA) -> cfg_pending = 1 and Prescale stays 32 until the frame completes and rx_line is high, then Prescale = 8.
- Host cfg_wr with cfg_prescale = 20 -> cfg_err pulse, Prescale and cfg_pending unchanged.
- A5 then a byte with rx_par_err = 1 -> frame_err pulse, err_cnt+1, FSM back in IDLE; a following clean A5,01,02 (plus CHK A6 if FRAME_CHK_EN) writes addr 0x01 data 0x02.
- With FRAME_CHK_EN defined: A5,12,34,00 -> frame_err pulse, no write, err_cnt+1.

Source files
------------

// File: rtl/uart_rx_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// uart_rx_cmd_ctrl
//
// Sits beside a UART receiver. It owns the receiver's run-time configuration
// and turns the received byte stream into command frames.
//
// Frame format:
//   SYNC, ADDR, DATA           (default build)
//   SYNC, ADDR, DATA, CHK      (FRAME_CHK_EN defined; CHK = SYNC ^ ADDR ^ DATA)
//
// A frame addressed to CFG_ADDR is a configuration request. Any other address
// produces a single-cycle register write.
//
// Optional feature macro: FRAME_CHK_EN (adds the CHK byte and its check).
//
// Ports:
//   CLK, RST          clock; synchronous active-high reset
//   rx_line           raw serial line (1 = idle), gates config apply
//   rx_data/rx_valid  receiver byte and valid; one byte per rx_valid rising edge
//   rx_par_err/stp    receiver error flags, sampled with the byte
//   cfg_wr/cfg_*      host configuration request
//   Prescale/PAR_EN/PAR_TYP  live configuration driven to the receiver
//   cfg_pending       a configuration change waits for an idle gap
//   cfg_err           pulse: illegal prescale requested
//   reg_wr_en/addr/wr_data   register write strobe and payload
//   frame_done/err    pulse per completed / aborted frame
//   err_cnt           saturating count of errored bytes, timeouts, CHK failures
// -----------------------------------------------------------------------------
module uart_rx_cmd_ctrl #(
  parameter int                    DATA_WIDTH   = 8,
  parameter logic [DATA_WIDTH-1:0] SYNC_BYTE    = 8'hA5,
  parameter logic [DATA_WIDTH-1:0] CFG_ADDR     = 8'hFF,
  parameter int                    TIMEOUT_BITS = 24
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  rx_line,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  input  logic                  rx_par_err,
  input  logic                  rx_stp_err,
  input  logic                  cfg_wr,
  input  logic [5:0]            cfg_prescale,
  input  logic                  cfg_par_en,
  input  logic                  cfg_par_typ,
  output logic [5:0]            Prescale,
  output logic                  PAR_EN,
  output logic                  PAR_TYP,
  output logic                  cfg_pending,
  output logic                  cfg_err,
  output logic                  reg_wr_en,
  output logic [DATA_WIDTH-1:0] reg_addr,
  output logic [DATA_WIDTH-1:0] reg_wr_data,
  output logic                  frame_done,
  output logic                  frame_err,
  output logic [7:0]            err_cnt
);

  // Timer must hold prescale (6 bits) times TIMEOUT_BITS.
  localparam int TMR_W = 6 + $clog2(TIMEOUT_BITS + 1);

  localparam logic [5:0] PS_8  = 6'd8;
  localparam logic [5:0] PS_16 = 6'd16;
  localparam logic [5:0] PS_32 = 6'd32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
`ifdef FRAME_CHK_EN
    ST_CHK,
`endif
    ST_EXEC
  } state_e;

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------
  state_e                state_q, state_d;

  // Byte event capture (one registered cycle of detection latency).
  logic                  rx_valid_q;
  logic                  byte_d;
  logic                  byte_q;
  logic                  byte_bad_q;
  logic [DATA_WIDTH-1:0] byte_data_q;

  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [TMR_W-1:0]      timer_q, timer_d;
  logic [7:0]            err_cnt_q, err_cnt_d;

  logic [5:0]            prescale_q, prescale_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic [5:0]            pend_prescale_q, pend_prescale_d;
  logic                  pend_par_en_q, pend_par_en_d;
  logic                  pend_par_typ_q, pend_par_typ_d;
  logic                  cfg_pending_q, cfg_pending_d;

  logic                  reg_wr_en_q, reg_wr_en_d;
  logic                  frame_done_q, frame_done_d;
  logic                  frame_err_q, frame_err_d;
  logic                  cfg_err_q, cfg_err_d;

  // Control signals shared between the next-state and output processes.
  logic                  in_frame;
  logic [TMR_W-1:0]      timeout_limit;
  logic                  timeout_hit;
  logic                  frame_abort;
  logic                  err_inc;
  logic                  exec_cfg;
  logic                  exec_legal;
  logic [5:0]            exec_prescale;
  logic                  host_legal;
  logic                  apply_cfg;

  assign byte_d = rx_valid & ~rx_valid_q;

  assign in_frame = (state_q == ST_ADDR) || (state_q == ST_DATA)
`ifdef FRAME_CHK_EN
                    || (state_q == ST_CHK)
`endif
                    ;

  // The limit follows the prescale actually in use by the receiver.
  assign timeout_limit = TMR_W'(prescale_q) * TMR_W'(TIMEOUT_BITS);
  assign timeout_hit   = in_frame && (timer_q >= timeout_limit - TMR_W'(1));

`ifdef FRAME_CHK_EN
  logic [DATA_WIDTH-1:0] chk_expect;
  assign chk_expect = SYNC_BYTE ^ addr_q ^ data_q;
`endif

  // ---------------------------------------------------------------------------
  // State register (all flops)
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q         <= ST_IDLE;
      rx_valid_q      <= 1'b0;
      byte_q          <= 1'b0;
      byte_bad_q      <= 1'b0;
      byte_data_q     <= '0;
      addr_q          <= '0;
      data_q          <= '0;
      timer_q         <= '0;
      err_cnt_q       <= '0;
      prescale_q      <= PS_32;
      par_en_q        <= 1'b1;
      par_typ_q       <= 1'b0;
      pend_prescale_q <= PS_32;
      pend_par_en_q   <= 1'b1;
      pend_par_typ_q  <= 1'b0;
      cfg_pending_q   <= 1'b0;
      reg_wr_en_q     <= 1'b0;
      frame_done_q    <= 1'b0;
      frame_err_q     <= 1'b0;
      cfg_err_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      rx_valid_q      <= rx_valid;
      byte_q          <= byte_d;
      byte_bad_q      <= rx_par_err | rx_stp_err;
      byte_data_q     <= rx_data;
      addr_q          <= addr_d;
      data_q          <= data_d;
      timer_q         <= timer_d;
      err_cnt_q       <= err_cnt_d;
      prescale_q      <= prescale_d;
      par_en_q        <= par_en_d;
      par_typ_q       <= par_typ_d;
      pend_prescale_q <= pend_prescale_d;
      pend_par_en_q   <= pend_par_en_d;
      pend_par_typ_q  <= pend_par_typ_d;
      cfg_pending_q   <= cfg_pending_d;
      reg_wr_en_q     <= reg_wr_en_d;
      frame_done_q    <= frame_done_d;
      frame_err_q     <= frame_err_d;
      cfg_err_q       <= cfg_err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic: frame parsing, field latching, inter-byte timer
  // ---------------------------------------------------------------------------
  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; that is what keeps this process free of inferred latches.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    timer_d     = timer_q;
    frame_abort = 1'b0;
    err_inc     = 1'b0;

    if (byte_q) begin
      timer_d = '0;
    end else if (in_frame) begin
      timer_d = timer_q + TMR_W'(1);
    end

    case (state_q)
      // EXEC lasts one cycle; a byte landing here is handled as in IDLE.
      ST_IDLE, ST_EXEC: begin
        state_d = ST_IDLE;
        if (byte_q) begin
          if (byte_bad_q) begin
            err_inc = 1'b1;
          end else if (byte_data_q == SYNC_BYTE) begin
            state_d = ST_ADDR;
          end
        end
      end

      ST_ADDR: begin
        if (byte_q) begin
          if (byte_bad_q) begin
            state_d     = ST_IDLE;
            frame_abort = 1'b1;
            err_inc     = 1'b1;
          end else begin
            addr_d  = byte_data_q;
            state_d = ST_DATA;
          end
        end else if (timeout_hit) begin
          state_d     = ST_IDLE;
          frame_abort = 1'b1;
          err_inc     = 1'b1;
        end
      end

      ST_DATA: begin
        if (byte_q) begin
          if (byte_bad_q) begin
            state_d     = ST_IDLE;
            frame_abort = 1'b1;
            err_inc     = 1'b1;
          end else begin
            data_d  = byte_data_q;
`ifdef FRAME_CHK_EN
            state_d = ST_CHK;
`else
            state_d = ST_EXEC;
`endif
          end
        end else if (timeout_hit) begin
          state_d     = ST_IDLE;
          frame_abort = 1'b1;
          err_inc     = 1'b1;
        end
      end

`ifdef FRAME_CHK_EN
      ST_CHK: begin
        if (byte_q) begin
          if (!byte_bad_q && (byte_data_q == chk_expect)) begin
            state_d = ST_EXEC;
          end else begin
            // Errored byte or checksum mismatch: both drop the frame.
            state_d     = ST_IDLE;
            frame_abort = 1'b1;
            err_inc     = 1'b1;
          end
        end else if (timeout_hit) begin
          state_d     = ST_IDLE;
          frame_abort = 1'b1;
          err_inc     = 1'b1;
        end
      end
`endif

      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic: strobes, error counter, configuration handling
  // ---------------------------------------------------------------------------
  assign exec_cfg   = (state_q == ST_EXEC) && (addr_q == CFG_ADDR);
  assign exec_legal = (data_q[1:0] != 2'b11);
  assign host_legal = (cfg_prescale == PS_8) || (cfg_prescale == PS_16) ||
                      (cfg_prescale == PS_32);
  // Config only moves while no frame is in flight and the line is idle, so
  // the receiver never sees a change in the middle of a character.
  assign apply_cfg  = (state_q == ST_IDLE) && cfg_pending_q && rx_line;

  always_comb begin
    case (data_q[1:0])
      2'd0:    exec_prescale = PS_8;
      2'd1:    exec_prescale = PS_16;
      default: exec_prescale = PS_32;
    endcase
  end

  always_comb begin
    reg_wr_en_d  = (state_q == ST_EXEC) && (addr_q != CFG_ADDR);
    frame_done_d = (state_q == ST_EXEC);
    frame_err_d  = frame_abort;
    cfg_err_d    = (cfg_wr && !host_legal) || (exec_cfg && !exec_legal);

    err_cnt_d = err_cnt_q;
    if (err_inc && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end

    prescale_d      = prescale_q;
    par_en_d        = par_en_q;
    par_typ_d       = par_typ_q;
    pend_prescale_d = pend_prescale_q;
    pend_par_en_d   = pend_par_en_q;
    pend_par_typ_d  = pend_par_typ_q;
    cfg_pending_d   = cfg_pending_q;

    if (apply_cfg) begin
      prescale_d    = pend_prescale_q;
      par_en_d      = pend_par_en_q;
      par_typ_d     = pend_par_typ_q;
      cfg_pending_d = 1'b0;
    end

    // A request arriving in the apply cycle stays pending for the next gap.
    // The host wins over an in-band request in the same cycle.
    if (cfg_wr && host_legal) begin
      pend_prescale_d = cfg_prescale;
      pend_par_en_d   = cfg_par_en;
      pend_par_typ_d  = cfg_par_typ;
      cfg_pending_d   = 1'b1;
    end else if (exec_cfg && exec_legal) begin
      pend_prescale_d = exec_prescale;
      pend_par_en_d   = data_q[2];
      pend_par_typ_d  = data_q[3];
      cfg_pending_d   = 1'b1;
    end
  end

  assign Prescale    = prescale_q;
  assign PAR_EN      = par_en_q;
  assign PAR_TYP     = par_typ_q;
  assign cfg_pending = cfg_pending_q;
  assign cfg_err     = cfg_err_q;
  assign reg_wr_en   = reg_wr_en_q;
  assign reg_addr    = addr_q;
  assign reg_wr_data = data_q;
  assign frame_done  = frame_done_q;
  assign frame_err   = frame_err_q;
  assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_uart_rx_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for uart_rx_cmd_ctrl: table-driven frames, hand-written sequences
// for timeout and config timing, and a randomized byte stream checked against a
// frame-level reference model.
// -----------------------------------------------------------------------------
module tb_uart_rx_cmd_ctrl;

  localparam logic [7:0] SYNC = 8'hA5;
`ifdef FRAME_CHK_EN
  localparam int FLEN = 4;
`else
  localparam int FLEN = 3;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_line;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_par_err;
  logic       rx_stp_err;
  logic       cfg_wr;
  logic [5:0] cfg_prescale;
  logic       cfg_par_en;
  logic       cfg_par_typ;
  logic [5:0] prescale;
  logic       par_en;
  logic       par_typ;
  logic       cfg_pending;
  logic       cfg_err;
  logic       reg_wr_en;
  logic [7:0] reg_addr;
  logic [7:0] reg_wr_data;
  logic       frame_done;
  logic       frame_err;
  logic [7:0] err_cnt;

  always #5 clk = ~clk;

  uart_rx_cmd_ctrl dut (
    .CLK          (clk),
    .RST          (rst),
    .rx_line      (rx_line),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_par_err   (rx_par_err),
    .rx_stp_err   (rx_stp_err),
    .cfg_wr       (cfg_wr),
    .cfg_prescale (cfg_prescale),
    .cfg_par_en   (cfg_par_en),
    .cfg_par_typ  (cfg_par_typ),
    .Prescale     (prescale),
    .PAR_EN       (par_en),
    .PAR_TYP      (par_typ),
    .cfg_pending  (cfg_pending),
    .cfg_err      (cfg_err),
    .reg_wr_en    (reg_wr_en),
    .reg_addr     (reg_addr),
    .reg_wr_data  (reg_wr_data),
    .frame_done   (frame_done),
    .frame_err    (frame_err),
    .err_cnt      (err_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Pulse monitor, sampled mid-cycle away from the active edge.
  int          n_wr = 0, n_done = 0, n_ferr = 0, n_cerr = 0;
  logic [15:0] obs_q[$];

  always @(negedge clk) begin
    #1;
    if (reg_wr_en === 1'b1) begin
      n_wr++;
      obs_q.push_back({reg_addr, reg_wr_data});
    end
    if (frame_done === 1'b1) n_done++;
    if (frame_err  === 1'b1) n_ferr++;
    if (cfg_err    === 1'b1) n_cerr++;
  end

  // Frame-level reference model: collects bytes of the current frame in a list.
  bit          model_on = 1'b0;
  logic [7:0]  fb[$];
  logic [15:0] exp_wr_q[$];
  int          m_done = 0, m_ferr = 0, m_err = 0;

  task automatic model_byte(input logic [7:0] b, input bit bad);
    if (bad) begin
      m_err++;
      if (fb.size() != 0) m_ferr++;
      fb.delete();
    end else if (fb.size() == 0) begin
      if (b == SYNC) fb.push_back(b);
    end else begin
      fb.push_back(b);
      if (fb.size() == FLEN) begin
        if (FLEN == 4 && fb[FLEN-1] != (fb[0] ^ fb[1] ^ fb[2])) begin
          m_ferr++;
          m_err++;
        end else begin
          m_done++;
          if (fb[1] != 8'hFF) exp_wr_q.push_back({fb[1], fb[2]});
        end
        fb.delete();
      end
    end
  endtask

  // One received character: start bit low, then a multi-cycle rx_valid pulse.
  task automatic send_byte(input logic [7:0] b, input bit perr, input bit serr,
                           input bit hold_low);
    @(negedge clk);
    rx_line = 1'b0;
    repeat (7) @(negedge clk);
    rx_line    = ~hold_low;
    rx_data    = b;
    rx_par_err = perr;
    rx_stp_err = serr;
    rx_valid   = 1'b1;
    if (model_on) model_byte(b, perr | serr);
    repeat (3) @(negedge clk);
    rx_valid   = 1'b0;
    rx_par_err = 1'b0;
    rx_stp_err = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  // Sends SYNC, addr, data[, chk]; the byte at err_pos carries an error and
  // ends the frame (stop-bit error on position 2, parity error elsewhere).
  task automatic send_frame(input logic [7:0] addr, input logic [7:0] data,
                            input int err_pos, input bit chk_bad);
    logic [7:0] b [4];
    bit         e;
    b[0] = SYNC;
    b[1] = addr;
    b[2] = data;
    b[3] = chk_bad ? 8'h00 : (SYNC ^ addr ^ data);
    for (int i = 0; i < FLEN; i++) begin
      e = (i == err_pos);
      send_byte(b[i], e && (i != 2), e && (i == 2), 1'b0);
      if (e) break;
    end
  endtask

  task automatic host_cfg(input logic [5:0] p, input bit en, input bit typ);
    @(negedge clk);
    cfg_wr       = 1'b1;
    cfg_prescale = p;
    cfg_par_en   = en;
    cfg_par_typ  = typ;
    @(negedge clk);
    cfg_wr = 1'b0;
  endtask

  int b_wr, b_done, b_ferr, b_cerr, b_err;
  task automatic snap();
    b_wr   = n_wr;
    b_done = n_done;
    b_ferr = n_ferr;
    b_cerr = n_cerr;
    b_err  = int'(err_cnt);
  endtask

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    int         err_pos;
    bit         chk_bad;
    int         exp_wr;
    int         exp_done;
    int         exp_ferr;
    int         exp_err;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    int n_items;
    int kind;
    int ep;
    bit cb;
    logic [7:0] a, d;

    vecs.push_back('{addr:8'h12, data:8'h34, err_pos:-1, chk_bad:1'b0,
                     exp_wr:1, exp_done:1, exp_ferr:0, exp_err:0});
    vecs.push_back('{addr:8'h55, data:8'h66, err_pos:1,  chk_bad:1'b0,
                     exp_wr:0, exp_done:0, exp_ferr:1, exp_err:1});
    vecs.push_back('{addr:8'h01, data:8'h02, err_pos:-1, chk_bad:1'b0,
                     exp_wr:1, exp_done:1, exp_ferr:0, exp_err:0});
    vecs.push_back('{addr:8'h77, data:8'h88, err_pos:0,  chk_bad:1'b0,
                     exp_wr:0, exp_done:0, exp_ferr:0, exp_err:1});
    vecs.push_back('{addr:8'h00, data:8'hFF, err_pos:2,  chk_bad:1'b0,
                     exp_wr:0, exp_done:0, exp_ferr:1, exp_err:1});
    vecs.push_back('{addr:8'hFE, data:8'h00, err_pos:-1, chk_bad:1'b0,
                     exp_wr:1, exp_done:1, exp_ferr:0, exp_err:0});
`ifdef FRAME_CHK_EN
    vecs.push_back('{addr:8'h12, data:8'h34, err_pos:-1, chk_bad:1'b1,
                     exp_wr:0, exp_done:0, exp_ferr:1, exp_err:1});
`endif

    rst          = 1'b1;
    rx_line      = 1'b1;
    rx_data      = '0;
    rx_valid     = 1'b0;
    rx_par_err   = 1'b0;
    rx_stp_err   = 1'b0;
    cfg_wr       = 1'b0;
    cfg_prescale = 6'd32;
    cfg_par_en   = 1'b1;
    cfg_par_typ  = 1'b0;

    // Reset values
    repeat (4) @(negedge clk);
    check("rst_prescale",    prescale,    6'd32);
    check("rst_par_en",      par_en,      1'b1);
    check("rst_par_typ",     par_typ,     1'b0);
    check("rst_cfg_pending", cfg_pending, 1'b0);
    check("rst_strobes", {reg_wr_en, frame_done, frame_err, cfg_err}, 4'b0000);
    check("rst_addr_data",   {reg_addr, reg_wr_data}, 16'h0000);
    check("rst_err_cnt",     err_cnt,     8'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Table-driven frames
    foreach (vecs[i]) begin
      snap();
      send_frame(vecs[i].addr, vecs[i].data, vecs[i].err_pos, vecs[i].chk_bad);
      repeat (3) @(negedge clk);
      check($sformatf("vec%0d_wr", i),   n_wr - b_wr,     vecs[i].exp_wr);
      check($sformatf("vec%0d_done", i), n_done - b_done, vecs[i].exp_done);
      check($sformatf("vec%0d_ferr", i), n_ferr - b_ferr, vecs[i].exp_ferr);
      check($sformatf("vec%0d_err", i),  int'(err_cnt) - b_err, vecs[i].exp_err);
      if (vecs[i].exp_wr != 0 && obs_q.size() != 0)
        check($sformatf("vec%0d_payload", i), obs_q[$], {vecs[i].addr, vecs[i].data});
    end

    // Inter-byte timeout: 00 ignored, A5, 12, then silence (limit 32*24)
    snap();
    send_byte(8'h00, 1'b0, 1'b0, 1'b0);
    send_byte(SYNC,  1'b0, 1'b0, 1'b0);
    send_byte(8'h12, 1'b0, 1'b0, 1'b0);
    cyc = 13;  // negedges already elapsed since the rx_valid rising edge
    while (n_ferr == b_ferr && cyc < 1200) begin
      @(negedge clk);
      cyc++;
    end
    check("timeout_window", (cyc >= 740 && cyc <= 800), 1'b1);
    check("timeout_ferr",   n_ferr - b_ferr, 1);
    check("timeout_err",    int'(err_cnt) - b_err, 1);
    check("timeout_no_wr",  n_wr - b_wr, 0);

    // In-band config frame A5,FF,0D -> prescale 16, parity on, odd
    snap();
    send_frame(8'hFF, 8'h0D, -1, 1'b0);
    repeat (3) @(negedge clk);
    check("cfgf_prescale", prescale, 6'd16);
    check("cfgf_par",      {par_en, par_typ}, 2'b11);
    check("cfgf_pending",  cfg_pending, 1'b0);
    check("cfgf_no_wr",    n_wr - b_wr, 0);
    check("cfgf_done",     n_done - b_done, 1);

    // Illegal host prescale
    snap();
    host_cfg(6'd20, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    check("illegal_cfg_err", n_cerr - b_cerr, 1);
    check("illegal_presc",   prescale, 6'd16);
    check("illegal_pending", cfg_pending, 1'b0);

    // Restore prescale 32 from the host
    host_cfg(6'd32, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    check("restore_presc", {prescale, par_en, par_typ}, {6'd32, 2'b10});

    // Host request mid-frame is deferred until IDLE with rx_line high
    snap();
    send_byte(SYNC,  1'b0, 1'b0, 1'b0);
    send_byte(8'h12, 1'b0, 1'b0, 1'b0);
    host_cfg(6'd8, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    check("mid_pending", cfg_pending, 1'b1);
    check("mid_presc_held", prescale, 6'd32);
`ifdef FRAME_CHK_EN
    send_byte(8'h34, 1'b0, 1'b0, 1'b0);
    send_byte(SYNC ^ 8'h12 ^ 8'h34, 1'b0, 1'b0, 1'b1);
`else
    send_byte(8'h34, 1'b0, 1'b0, 1'b1);
`endif
    check("mid_wr", n_wr - b_wr, 1);
    check("mid_line_low_presc", prescale, 6'd32);
    check("mid_line_low_pending", cfg_pending, 1'b1);
    rx_line = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_applied_presc", prescale, 6'd8);
    check("mid_applied_pending", cfg_pending, 1'b0);

    // Randomized stream against the reference model (prescale 8)
    obs_q.delete();
    exp_wr_q.delete();
    fb.delete();
    m_done   = 0;
    m_ferr   = 0;
    m_err    = 0;
    model_on = 1'b1;
    snap();
    n_items = 50;
    for (int k = 0; k < n_items; k++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        send_byte(8'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b0);
      end else if (kind == 1) begin
        send_byte(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b1, 1'b0);
      end else begin
        a  = 8'($urandom_range(0, 254));
        d  = 8'($urandom_range(0, 255));
        ep = ($urandom_range(0, 5) == 0) ? $urandom_range(0, FLEN - 1) : -1;
`ifdef FRAME_CHK_EN
        cb = ($urandom_range(0, 4) == 0);
`else
        cb = 1'b0;
`endif
        send_frame(a, d, ep, cb);
      end
    end
    // A partially received frame is left to time out.
    repeat (300) @(negedge clk);
    if (fb.size() != 0) begin
      m_ferr++;
      m_err++;
      fb.delete();
    end
    model_on = 1'b0;
    check("rand_wr_count", obs_q.size(), exp_wr_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_wr_q.size(); i++)
      check($sformatf("rand_wr%0d", i), obs_q[i], exp_wr_q[i]);
    check("rand_done", n_done - b_done, m_done);
    check("rand_ferr", n_ferr - b_ferr, m_ferr);
    check("rand_err",  int'(err_cnt) - b_err, m_err);

    // err_cnt saturation: errored bytes in IDLE never raise frame_err
    snap();
    for (int k = 0; k < 260; k++) send_byte(8'h00, 1'b1, 1'b0, 1'b0);
    check("sat_err_cnt", err_cnt, 8'd255);
    check("sat_no_ferr", n_ferr - b_ferr, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
